// File: rtl/gpio_midi_scheduler.sv
// GPIO-to-MIDI bridge: synchronizes and debounces eight pins, queues key edges in an
// 8-deep FIFO and streams each one to the UART as a 3-byte Note-On/Note-Off message.
module gpio_midi_scheduler #(
  parameter int unsigned debounce_cycles = 16,
  parameter int unsigned midi_channel    = 0,
  parameter int unsigned base_note       = 60,
  parameter int unsigned velocity        = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] gpio_i,
  input  logic [7:0] gpio_dir,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_busy,
  output logic [3:0] ev_count,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int unsigned CntW = $clog2(debounce_cycles);
  localparam logic [CntW-1:0] CntMax = CntW'(debounce_cycles - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStat,
    StNote,
    StVel,
    StGap1,
    StGap2,
    StGap3
  } tx_state_e;

  logic [7:0]      sync1_q, sync2_q;
  logic [7:0]      stable_q, stable_d;
  logic [7:0]      tog_q, tog_d;
  logic [CntW-1:0] cnt_q [8];
  logic [CntW-1:0] cnt_d [8];

  logic [7:0] pend_q, pend_d;
  logic [7:0] lvl_q, lvl_d;
  logic       ovf_set;
  logic       overflow_q;

  logic [3:0] fifo_q [8];
  logic [2:0] wr_ptr_q, rd_ptr_q;
  logic [3:0] count_q, count_d;
  logic       full, enq, pop;
  logic [2:0] enq_idx;

  tx_state_e  state_q;
  logic [3:0] msg_q;
  logic [7:0] tx_data_q;
  logic       tx_wr_q;
  logic [7:0] status_byte, note_byte, vel_byte;
  logic [6:0] note_lo;

  // Synchronizer, debounced state and the one-cycle toggle marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      tog_q    <= '0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= gpio_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      tog_q    <= tog_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Output-direction pins track the pad directly so unmasking never fires an edge.
  always_comb begin
    stable_d = stable_q;
    tog_d    = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (gpio_dir[i]) begin
        stable_d[i] = sync2_q[i];
      end else if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = ~stable_q[i];
          tog_d[i]    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    enq_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) enq_idx = 3'(i);
    end
  end

  assign full    = (count_q == 4'd8);
  assign enq     = (|pend_q) && !full;
  assign pop     = (state_q == StIdle) && enable && (count_q != 4'd0);
  assign count_d = count_q + {3'b000, enq} - {3'b000, pop};

  // A second edge on a still-pending bit cancels the first and flags the loss.
  always_comb begin
    pend_d  = pend_q;
    lvl_d   = lvl_q;
    ovf_set = 1'b0;
    if (enq) pend_d[enq_idx] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tog_q[i]) begin
        if (pend_d[i]) begin
          pend_d[i] = 1'b0;
          ovf_set   = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          lvl_d[i]  = stable_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= '0;
      lvl_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      lvl_q  <= lvl_d;
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < 8; i++) fifo_q[i] <= '0;
    end else begin
      if (enq) begin
        fifo_q[wr_ptr_q] <= {lvl_q[enq_idx], enq_idx};
        wr_ptr_q         <= wr_ptr_q + 3'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 3'd1;
      count_q <= count_d;
    end
  end

  assign note_lo     = 7'(base_note) + {4'b0000, msg_q[2:0]};
  assign status_byte = {(msg_q[3] ? 4'h9 : 4'h8), 4'(midi_channel)};
  assign note_byte   = {1'b0, note_lo};
  assign vel_byte    = msg_q[3] ? {1'b0, 7'(velocity)} : 8'h40;

  // Gap states give the UART one cycle to raise busy after each strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      msg_q     <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
    end else begin
      tx_wr_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            msg_q   <= fifo_q[rd_ptr_q];
            state_q <= StStat;
          end
        end
        StStat: begin
          if (!tx_busy) begin
            tx_data_q <= status_byte;
            tx_wr_q   <= 1'b1;
            state_q   <= StGap1;
          end
        end
        StNote: begin
          if (!tx_busy) begin
            tx_data_q <= note_byte;
            tx_wr_q   <= 1'b1;
            state_q   <= StGap2;
          end
        end
        StVel: begin
          if (!tx_busy) begin
            tx_data_q <= vel_byte;
            tx_wr_q   <= 1'b1;
            state_q   <= StGap3;
          end
        end
        StGap1:  state_q <= StNote;
        StGap2:  state_q <= StVel;
        StGap3:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_wr    = tx_wr_q;
  assign ev_count = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_gpio_midi_scheduler.sv
// Directed and randomized bench for gpio_midi_scheduler with a simple UART busy model
// and a message-level reference model of the expected MIDI byte stream.
module tb_gpio_midi_scheduler;

  localparam int unsigned Deb  = 16;
  localparam int unsigned Chan = 0;
  localparam int unsigned Base = 60;
  localparam int unsigned Vel  = 100;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] gpio_i;
  logic [7:0] gpio_dir;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;
  logic [3:0] ev_count;
  logic       overflow;
  logic       clr_overflow;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int  wr_count   = 0;
  int  busy_cnt   = 0;
  int  busy_len   = 10;
  int  ev_peak    = 0;
  logic force_busy = 1'b0;

  gpio_midi_scheduler #(
    .debounce_cycles(Deb),
    .midi_channel   (Chan),
    .base_note      (Base),
    .velocity       (Vel)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .gpio_i      (gpio_i),
    .gpio_dir    (gpio_dir),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_busy     (tx_busy),
    .ev_count    (ev_count),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  assign tx_busy = force_busy | (busy_cnt != 0);

  // UART model: capture strobed bytes and hold busy for busy_len cycles afterwards.
  always @(negedge clk) begin
    if (tx_wr) begin
      rx_q.push_back(tx_data);
      wr_count++;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    if (int'(ev_count) > ev_peak) ev_peak = int'(ev_count);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected MIDI message for one key event, straight from the byte rules.
  task automatic push_msg(input bit lvl, input int idx);
    exp_q.push_back(lvl ? (8'h90 | 8'(Chan)) : (8'h80 | 8'(Chan)));
    exp_q.push_back(8'((Base + idx) % 128));
    exp_q.push_back(lvl ? 8'(Vel) : 8'h40);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      check({tag, "_byte"}, rx_q[k], exp_q[k]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b0;
    gpio_i       = 8'h00;
    gpio_dir     = 8'h00;
    clr_overflow = 1'b0;
    force_busy   = 1'b0;
    tick(3);
    rx_q.delete();
    exp_q.delete();
    wr_count = 0;
    busy_cnt = 0;
    ev_peak  = 0;
    rst      = 1'b1;
    tick(2);
  endtask

  initial begin
    int lat;
    int k;
    logic [7:0] model_stable;
    logic [7:0] dir_r;
    logic [7:0] val_r;

    rst          = 1'b0;
    enable       = 1'b0;
    gpio_i       = 8'h00;
    gpio_dir     = 8'h00;
    clr_overflow = 1'b0;

    // Reset values and single-key latency / message contents.
    do_reset();
    check("rst_tx_wr", tx_wr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ev_count", ev_count, 0);
    check("rst_overflow", overflow, 0);
    enable   = 1'b1;
    busy_len = 10;
    gpio_i   = 8'h01;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (tx_wr) break;
    end
    check("latency", lat, Deb + 6);
    tick(40);
    push_msg(1'b1, 0);
    wait_rx(3, 500);
    gpio_i = 8'h00;
    push_msg(1'b0, 0);
    wait_rx(6, 500);
    tick(50);
    compare_stream("bit0");
    check("bit0_wr_pulses", wr_count, 6);

    // Masked pins: only bits 1 and 3 produce events, lowest index first.
    do_reset();
    enable   = 1'b0;
    gpio_dir = 8'hF0;
    gpio_i   = 8'hAA;
    tick(40);
    check("mask_ev_count", ev_count, 2);
    enable = 1'b1;
    push_msg(1'b1, 1);
    push_msg(1'b1, 3);
    wait_rx(6, 500);
    tick(20);
    compare_stream("mask");
    check("mask_peak", ev_peak, 2);

    // Glitch shorter than the debounce window is ignored.
    do_reset();
    enable = 1'b1;
    gpio_i = 8'h04;
    tick(Deb - 2);
    gpio_i = 8'h00;
    tick(60);
    check("glitch_wr", wr_count, 0);
    check("glitch_peak", ev_peak, 0);
    check("glitch_overflow", overflow, 0);

    // FIFO fill with enable low, pending hold, collapse overflow, drain in order.
    do_reset();
    enable = 1'b0;
    gpio_i = 8'h0F;
    tick(40);
    gpio_i = 8'h00;
    tick(40);
    check("full_ev_count", ev_count, 8);
    gpio_i = 8'h01;
    tick(40);
    check("full_hold_ev_count", ev_count, 8);
    check("full_no_overflow", overflow, 0);
    gpio_i = 8'h00;
    tick(40);
    check("collapse_overflow", overflow, 1);
    for (int i = 0; i < 4; i++) push_msg(1'b1, i);
    for (int i = 0; i < 4; i++) push_msg(1'b0, i);
    enable = 1'b1;
    wait_rx(24, 3000);
    tick(60);
    compare_stream("drain");
    check("drain_wr_pulses", wr_count, 24);
    check("drain_ev_count", ev_count, 0);
    check("overflow_sticky", overflow, 1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    tick(1);
    check("overflow_cleared", overflow, 0);

    // Long busy stall, then release: status byte strobes on the next edge.
    do_reset();
    enable     = 1'b1;
    busy_len   = 10;
    force_busy = 1'b1;
    gpio_i     = 8'h01;
    tick(200);
    check("stall_wr", wr_count, 0);
    check("stall_tx_wr", tx_wr, 0);
    force_busy = 1'b0;
    @(posedge clk);
    #1;
    check("release_tx_wr", tx_wr, 1);
    check("release_tx_data", tx_data, 8'h90);
    gpio_i = 8'h00;
    k = 0;
    while (wr_count < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("vel_wait_wr", wr_count, 2);
    force_busy = 1'b1;
    tick(40);
    check("vel_wait_ev_count", ev_count, 1);
    check("vel_wait_no_byte", wr_count, 2);

    // Asynchronous reset mid-message clears outputs immediately.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_tx_wr", tx_wr, 0);
    check("async_ev_count", ev_count, 0);
    check("async_overflow", overflow, 0);
    check("async_tx_data", tx_data, 0);
    tick(2);
    force_busy = 1'b0;
    busy_cnt   = 0;
    wr_count   = 0;
    rst        = 1'b1;
    tick(100);
    check("post_reset_silent", wr_count, 0);

    // Randomized pin/direction patterns against the message-level model.
    do_reset();
    enable       = 1'b1;
    model_stable = 8'h00;
    for (int p = 0; p < 12; p++) begin
      dir_r = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      val_r = 8'($urandom_range(0, 255));
      rx_q.delete();
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
        if (!dir_r[i] && (val_r[i] != model_stable[i])) push_msg(val_r[i], i);
      end
      model_stable = val_r;
      @(negedge clk);
      busy_len = $urandom_range(0, 4);
      gpio_dir = dir_r;
      gpio_i   = val_r;
      tick(40);
      wait_rx(exp_q.size(), 3000);
      tick(30);
      compare_stream("rand");
      check("rand_ev_count", ev_count, 0);
    end
    check("rand_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
